// File: rtl/video_timing_gen_pkg.sv
// video_timing_pkg
//   Shared timing definitions for the video timing generator: the mode
//   enumeration, the per-axis timing record, the table of supported modes
//   and small helpers that derive sync window bounds from a timing record.
//   No ports (package).
package video_timing_pkg;

  localparam int TIMING_W = 12;

  typedef enum logic {
    MODE_720P = 1'b0,
    MODE_480P = 1'b1
  } mode_e;

  // One axis of a video mode, in the order active / front porch / sync /
  // back porch / total. polarity is the asserted level of the sync strobe.
  typedef struct packed {
    logic [TIMING_W-1:0] active;
    logic [TIMING_W-1:0] fp;
    logic [TIMING_W-1:0] sync;
    logic [TIMING_W-1:0] bp;
    logic [TIMING_W-1:0] total;
    logic                polarity;
  } timing_t;

  typedef struct packed {
    timing_t h;
    timing_t v;
  } mode_timing_t;

  // Indexed by mode_e: entry 0 is 1280x720@60, entry 1 is 640x480@60.
  localparam mode_timing_t MODE_TABLE [2] = '{
    '{h: '{active: 12'd1280, fp: 12'd110, sync: 12'd40, bp: 12'd220,
           total: 12'd1650, polarity: 1'b1},
      v: '{active: 12'd720,  fp: 12'd5,   sync: 12'd5,  bp: 12'd20,
           total: 12'd750,  polarity: 1'b1}},
    '{h: '{active: 12'd640,  fp: 12'd16,  sync: 12'd96, bp: 12'd48,
           total: 12'd800,  polarity: 1'b0},
      v: '{active: 12'd480,  fp: 12'd10,  sync: 12'd2,  bp: 12'd33,
           total: 12'd525,  polarity: 1'b0}}
  };

  // First index inside the sync window.
  function automatic int sync_start(timing_t t);
    return int'(t.active) + int'(t.fp);
  endfunction

  // First index past the sync window.
  function automatic int sync_end(timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync);
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if
//   Bundle of everything the timing generator publishes to its consumers
//   (render pipeline, TMDS encoders).
//   master: generator side, drives every signal.
//   slave : consumer side, observes every signal.
//   Parameters H_BITS / V_BITS / FC_BITS size the counters.
interface video_timing_gen_if #(
  parameter int H_BITS  = 11,
  parameter int V_BITS  = 10,
  parameter int FC_BITS = 6
);
  import video_timing_pkg::*;

  mode_e               mode;
  logic [H_BITS-1:0]   hcount;
  logic [V_BITS-1:0]   vcount;
  logic                hs;
  logic                vs;
  logic                ad;
  logic                nf;
  logic [FC_BITS-1:0]  fc;
  logic                hs_d;
  logic                vs_d;
  logic                ad_d;

  modport master (
    output mode, hcount, vcount, hs, vs, ad, nf, fc, hs_d, vs_d, ad_d
  );

  modport slave (
    input  mode, hcount, vcount, hs, vs, ad, nf, fc, hs_d, vs_d, ad_d
  );

endinterface

// File: rtl/video_timing_gen_sync_delay_line.sv
// sync_delay_line
//   Enable-gated shift register of DEPTH stages, WIDTH bits wide. Each stage
//   samples the previous one only when en is high, so the delay is counted
//   in enabled cycles. DEPTH = 0 degenerates to a straight wire.
//   clk   : clock
//   rst_n : asynchronous active-low clear, every stage loads RESET_VAL
//   en    : shift enable
//   d     : input word
//   q     : word from the last stage (or d when DEPTH = 0)
module sync_delay_line #(
  parameter int               DEPTH     = 0,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Control inputs have no job without any stages.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, en};
      assign q = d;
    end else begin : g_stages
      logic [DEPTH-1:0][WIDTH-1:0] stage_q;
      logic [DEPTH-1:0][WIDTH-1:0] stage_d;

      always_comb begin
        stage_d = stage_q;
        if (en) begin
          stage_d[0] = d;
          for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q <= {DEPTH{RESET_VAL}};
        end else begin
          stage_q <= stage_d;
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Two-mode video timing generator (1280x720@60 / 640x480@60). Produces
//   pixel/line counters, registered sync and active-draw strobes, a one-cycle
//   new-frame pulse with a frame counter, and copies of the strobes delayed
//   by ALIGN_DELAY enabled cycles (legal 0..15) to match render latency.
//   clk_pixel_in : pixel clock
//   rst_n_in     : asynchronous active-low reset
//   en_in        : count enable, all state holds while low
//   mode_in      : requested mode, adopted only at the frame boundary
//   mode_out     : mode currently generated
//   hcount_out / vcount_out : pixel and line index
//   hs_out / vs_out / ad_out : sync strobes (mode polarity) and active draw
//   nf_out / fc_out          : new-frame pulse and frame count
//   hs_d_out / vs_d_out / ad_d_out : delayed strobes
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter  int H_BITS      = 11,
  parameter  int V_BITS      = 10,
  parameter  int FC_WRAP     = 60,
  parameter  int ALIGN_DELAY = 0,
  localparam int FC_BITS     = $clog2(FC_WRAP)
) (
  input  logic               clk_pixel_in,
  input  logic               rst_n_in,
  input  logic               en_in,
  input  logic               mode_in,
  output logic               mode_out,
  output logic [H_BITS-1:0]  hcount_out,
  output logic [V_BITS-1:0]  vcount_out,
  output logic               hs_out,
  output logic               vs_out,
  output logic               ad_out,
  output logic               nf_out,
  output logic [FC_BITS-1:0] fc_out,
  output logic               hs_d_out,
  output logic               vs_d_out,
  output logic               ad_d_out
);

  // Per-mode bounds resized to the counter widths, indexed by mode_e.
  localparam logic [H_BITS-1:0] H_LAST [2] = '{
    H_BITS'(int'(MODE_TABLE[0].h.total) - 1), H_BITS'(int'(MODE_TABLE[1].h.total) - 1)};
  localparam logic [V_BITS-1:0] V_LAST [2] = '{
    V_BITS'(int'(MODE_TABLE[0].v.total) - 1), V_BITS'(int'(MODE_TABLE[1].v.total) - 1)};
  localparam logic [H_BITS-1:0] H_ACT [2] = '{
    H_BITS'(MODE_TABLE[0].h.active), H_BITS'(MODE_TABLE[1].h.active)};
  localparam logic [V_BITS-1:0] V_ACT [2] = '{
    V_BITS'(MODE_TABLE[0].v.active), V_BITS'(MODE_TABLE[1].v.active)};
  localparam logic [H_BITS-1:0] H_SS [2] = '{
    H_BITS'(sync_start(MODE_TABLE[0].h)), H_BITS'(sync_start(MODE_TABLE[1].h))};
  localparam logic [H_BITS-1:0] H_SE [2] = '{
    H_BITS'(sync_end(MODE_TABLE[0].h)), H_BITS'(sync_end(MODE_TABLE[1].h))};
  localparam logic [V_BITS-1:0] V_SS [2] = '{
    V_BITS'(sync_start(MODE_TABLE[0].v)), V_BITS'(sync_start(MODE_TABLE[1].v))};
  localparam logic [V_BITS-1:0] V_SE [2] = '{
    V_BITS'(sync_end(MODE_TABLE[0].v)), V_BITS'(sync_end(MODE_TABLE[1].v))};
  localparam logic H_POL [2] = '{MODE_TABLE[0].h.polarity, MODE_TABLE[1].h.polarity};
  localparam logic V_POL [2] = '{MODE_TABLE[0].v.polarity, MODE_TABLE[1].v.polarity};
  localparam logic [FC_BITS-1:0] FC_LAST = FC_BITS'(FC_WRAP - 1);

  mode_e               mode_q, mode_d;
  logic [H_BITS-1:0]   hcount_q, hcount_d;
  logic [V_BITS-1:0]   vcount_q, vcount_d;
  logic [FC_BITS-1:0]  fc_q, fc_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic                ad_q, ad_d;
  logic                nf_q, nf_d;
  logic                line_end, frame_end;
  logic                h_in_sync, v_in_sync, at_nf;
  logic [2:0]          strobes_dly;

  // Counter advance. Wrap points come from the mode being generated now;
  // the requested mode is latched only as the counters return to (0,0).
  always_comb begin
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    mode_d    = mode_q;
    line_end  = (hcount_q == H_LAST[mode_q]);
    frame_end = line_end && (vcount_q == V_LAST[mode_q]);
    if (en_in) begin
      if (line_end) begin
        hcount_d = '0;
        vcount_d = frame_end ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
      if (frame_end) begin
        mode_d = mode_e'(mode_in);
      end
    end
  end

  // Strobes are decoded from the next counter values and next mode so the
  // registered strobes line up with the registered counters.
  always_comb begin
    hs_d      = hs_q;
    vs_d      = vs_q;
    ad_d      = ad_q;
    nf_d      = 1'b0;
    fc_d      = fc_q;
    h_in_sync = (hcount_d >= H_SS[mode_d]) && (hcount_d < H_SE[mode_d]);
    v_in_sync = (vcount_d >= V_SS[mode_d]) && (vcount_d < V_SE[mode_d]);
    at_nf     = (hcount_d == H_ACT[mode_d]) && (vcount_d == V_ACT[mode_d]);
    if (en_in) begin
      ad_d = (hcount_d < H_ACT[mode_d]) && (vcount_d < V_ACT[mode_d]);
      hs_d = h_in_sync ? H_POL[mode_d] : ~H_POL[mode_d];
      vs_d = v_in_sync ? V_POL[mode_d] : ~V_POL[mode_d];
      nf_d = at_nf;
      if (at_nf) begin
        fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mode_q   <= MODE_720P;
      hcount_q <= '0;
      vcount_q <= '0;
      fc_q     <= '0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      ad_q     <= 1'b0;
      nf_q     <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      fc_q     <= fc_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ad_q     <= ad_d;
      nf_q     <= nf_d;
    end
  end

  sync_delay_line #(
    .DEPTH     (ALIGN_DELAY),
    .WIDTH     (3),
    .RESET_VAL (3'b000)
  ) u_align (
    .clk   (clk_pixel_in),
    .rst_n (rst_n_in),
    .en    (en_in),
    .d     ({hs_q, vs_q, ad_q}),
    .q     (strobes_dly)
  );

  assign mode_out   = mode_q;
  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign fc_out     = fc_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign ad_out     = ad_q;
  assign nf_out     = nf_q;
  assign hs_d_out   = strobes_dly[2];
  assign vs_d_out   = strobes_dly[1];
  assign ad_d_out   = strobes_dly[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
//   Directed bench for video_timing_gen with ALIGN_DELAY = 3. A small
//   behavioural model built from hand-entered mode numbers predicts every
//   output each cycle. Counters are preloaded by force while the generator
//   is disabled so that distant frame positions are reached quickly.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam int H_BITS      = 11;
  localparam int V_BITS      = 10;
  localparam int FC_WRAP     = 60;
  localparam int ALIGN_DELAY = 3;
  localparam int FC_BITS     = 6;

  localparam int M_HACT [2] = '{1280, 640};
  localparam int M_HFP  [2] = '{110, 16};
  localparam int M_HSYN [2] = '{40, 96};
  localparam int M_HTOT [2] = '{1650, 800};
  localparam int M_VACT [2] = '{720, 480};
  localparam int M_VFP  [2] = '{5, 10};
  localparam int M_VSYN [2] = '{5, 2};
  localparam int M_VTOT [2] = '{750, 525};
  localparam bit M_POL  [2] = '{1'b1, 1'b0};

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               mode_in;
  logic               mode_out;
  logic [H_BITS-1:0]  hcount_out;
  logic [V_BITS-1:0]  vcount_out;
  logic               hs_out, vs_out, ad_out, nf_out;
  logic [FC_BITS-1:0] fc_out;
  logic               hs_d_out, vs_d_out, ad_d_out;

  logic [H_BITS-1:0]  pre_h;
  logic [V_BITS-1:0]  pre_v;
  logic [FC_BITS-1:0] pre_fc;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // model state
  int       m_h, m_v, m_fc, m_mode;
  bit       m_hs, m_vs, m_ad, m_nf;
  bit [2:0] m_dl [ALIGN_DELAY];

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_BITS      (H_BITS),
    .V_BITS      (V_BITS),
    .FC_WRAP     (FC_WRAP),
    .ALIGN_DELAY (ALIGN_DELAY)
  ) dut (
    .clk_pixel_in (clk),
    .rst_n_in     (rst_n),
    .en_in        (en),
    .mode_in      (mode_in),
    .mode_out     (mode_out),
    .hcount_out   (hcount_out),
    .vcount_out   (vcount_out),
    .hs_out       (hs_out),
    .vs_out       (vs_out),
    .ad_out       (ad_out),
    .nf_out       (nf_out),
    .fc_out       (fc_out),
    .hs_d_out     (hs_d_out),
    .vs_d_out     (vs_d_out),
    .ad_d_out     (ad_d_out)
  );

  video_timing_gen_if #(.H_BITS(H_BITS), .V_BITS(V_BITS), .FC_BITS(FC_BITS)) vif ();

  assign vif.mode   = mode_e'(mode_out);
  assign vif.hcount = hcount_out;
  assign vif.vcount = vcount_out;
  assign vif.hs     = hs_out;
  assign vif.vs     = vs_out;
  assign vif.ad     = ad_out;
  assign vif.nf     = nf_out;
  assign vif.fc     = fc_out;
  assign vif.hs_d   = hs_d_out;
  assign vif.vs_d   = vs_d_out;
  assign vif.ad_d   = ad_d_out;

  function automatic bit syncLevel(int c, int act, int fp, int syn, bit pol);
    bit inside_win;
    inside_win = (c >= act + fp) && (c < act + fp + syn);
    return inside_win ? pol : !pol;
  endfunction

  task automatic modelReset();
    m_h = 0; m_v = 0; m_fc = 0; m_mode = 0;
    m_hs = 1'b0; m_vs = 1'b0; m_ad = 1'b0; m_nf = 1'b0;
    for (int i = 0; i < ALIGN_DELAY; i++) m_dl[i] = 3'b000;
  endtask

  task automatic modelStep(input bit en_v, input bit req);
    bit boundary;
    if (!en_v) begin
      m_nf = 1'b0;
      return;
    end
    boundary = (m_h == M_HTOT[m_mode] - 1) && (m_v == M_VTOT[m_mode] - 1);
    for (int i = ALIGN_DELAY - 1; i > 0; i--) m_dl[i] = m_dl[i-1];
    m_dl[0] = {m_hs, m_vs, m_ad};
    if (m_h == M_HTOT[m_mode] - 1) begin
      m_h = 0;
      m_v = (m_v == M_VTOT[m_mode] - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    if (boundary) m_mode = int'(req);
    m_ad = (m_h < M_HACT[m_mode]) && (m_v < M_VACT[m_mode]);
    m_hs = syncLevel(m_h, M_HACT[m_mode], M_HFP[m_mode], M_HSYN[m_mode], M_POL[m_mode]);
    m_vs = syncLevel(m_v, M_VACT[m_mode], M_VFP[m_mode], M_VSYN[m_mode], M_POL[m_mode]);
    m_nf = (m_h == M_HACT[m_mode]) && (m_v == M_VACT[m_mode]);
    if (m_nf) m_fc = (m_fc == FC_WRAP - 1) ? 0 : m_fc + 1;
  endtask

  task automatic checkOne(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) else begin
      bad_cnt++;
      $error("[TB] FAIL %s observed=%0d expected=%0d (model h=%0d v=%0d) t=%0t",
             tag, observed, expected, m_h, m_v, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("mode",   32'(vif.mode),   32'(m_mode));
    checkOne("hcount", 32'(vif.hcount), 32'(m_h));
    checkOne("vcount", 32'(vif.vcount), 32'(m_v));
    checkOne("hs",     32'(vif.hs),     32'(m_hs));
    checkOne("vs",     32'(vif.vs),     32'(m_vs));
    checkOne("ad",     32'(vif.ad),     32'(m_ad));
    checkOne("nf",     32'(vif.nf),     32'(m_nf));
    checkOne("fc",     32'(vif.fc),     32'(m_fc));
    checkOne("hs_d",   32'(vif.hs_d),   32'(m_dl[ALIGN_DELAY-1][2]));
    checkOne("vs_d",   32'(vif.vs_d),   32'(m_dl[ALIGN_DELAY-1][1]));
    checkOne("ad_d",   32'(vif.ad_d),   32'(m_dl[ALIGN_DELAY-1][0]));
  endtask

  // Drive inputs, take one clock edge, advance the model, check 1 ns later.
  task automatic applyStimulus(input bit en_v, input bit req, input int n);
    for (int i = 0; i < n; i++) begin
      en      = en_v;
      mode_in = req;
      @(posedge clk);
      modelStep(en_v, req);
      #1;
      checkOutput();
    end
  endtask

  // Enable dropped on every fifth cycle to exercise the enabled-cycle delay.
  task automatic runGapped(input bit req, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus((i % 5) != 2, req, 1);
    end
  endtask

  // Jump the counters to (h, v) and the frame count to fc during a disabled
  // edge; strobes and delay line hold, exactly as the model does.
  task automatic preload(input int h, input int v, input int fc);
    en     = 1'b0;
    pre_h  = H_BITS'(h);
    pre_v  = V_BITS'(v);
    pre_fc = FC_BITS'(fc);
    force dut.hcount_q = pre_h;
    force dut.vcount_q = pre_v;
    force dut.fc_q     = pre_fc;
    @(posedge clk);
    #1;
    release dut.hcount_q;
    release dut.vcount_q;
    release dut.fc_q;
    modelStep(1'b0, 1'b0);
    m_h  = h;
    m_v  = v;
    m_fc = fc;
  endtask

  initial begin
    $display("[TB] video_timing_gen directed test start");
    rst_n   = 1'b0;
    en      = 1'b0;
    mode_in = 1'b0;
    pre_h   = '0;
    pre_v   = '0;
    pre_fc  = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    #2 rst_n = 1'b1;

    $display("[TB] hold after reset, then first mode-0 lines");
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 1700);

    $display("[TB] enable gaps through the delay line");
    runGapped(1'b0, 200);

    $display("[TB] new-frame pulse and enable freeze at (1280,720)");
    preload(1275, 720, 0);
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b0, 1'b0, 37);
    applyStimulus(1'b1, 1'b0, 20);

    $display("[TB] mode-0 vertical sync window");
    preload(1640, 723, 1);
    applyStimulus(1'b1, 1'b0, 1650 * 8);

    $display("[TB] mode request mid-frame, adopted at frame boundary");
    preload(495, 300, 1);
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 50);
    preload(1640, 749, 1);
    applyStimulus(1'b1, 1'b1, 900);
    applyStimulus(1'b1, 1'b0, 100);

    $display("[TB] mode-1 frame counter wrap and vertical sync");
    preload(635, 480, 59);
    applyStimulus(1'b1, 1'b0, 10);
    preload(795, 489, 0);
    runGapped(1'b0, 2400);

    $display("[TB] return to mode 0 at frame boundary");
    preload(795, 524, 0);
    applyStimulus(1'b1, 1'b0, 20);

    $display("[TB] asynchronous reset mid-line");
    preload(800, 400, 3);
    applyStimulus(1'b1, 1'b0, 12);
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
